// File: rtl/sd_bridge_pkg.sv
// rtl/sd_bridge_pkg.sv - shared state type and lane helper for the Wishbone byte bridge
package sd_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } bridge_state_t;

  function automatic logic [1:0] hi_lane(input logic [3:0] mask);
    if (mask[3])      return 2'd3;
    else if (mask[2]) return 2'd2;
    else if (mask[1]) return 2'd1;
    else              return 2'd0;
  endfunction

endpackage

// File: rtl/sd_wb_byte_bridge.sv
// rtl/sd_wb_byte_bridge.sv - Wishbone classic word port to byte-wide register port bridge
module sd_wb_byte_bridge
  import sd_bridge_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  input  logic [7:0]        reg_rdata_i
);

  bridge_state_t     state_q, state_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-3:0] wadr_q, wadr_d;
  logic              we_q, we_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              ack_q, ack_d;
  logic [31:0]       wb_dat_q, wb_dat_d;

  logic [1:0]        first_lane, cur_lane, nxt_lane;
  logic [3:0]        rest_mask;
  logic [31:0]       rbuf_next;

  logic unused_adr_lsb;
  assign unused_adr_lsb = ^wb_adr_i[1:0];

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    wadr_d      = wadr_q;
    we_d        = we_q;
    wdat_d      = wdat_q;
    rbuf_d      = rbuf_q;
    reg_we_d    = reg_we_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    ack_d       = 1'b0;
    wb_dat_d    = wb_dat_q;
    first_lane  = hi_lane(wb_sel_i);
    cur_lane    = hi_lane(mask_q);
    rest_mask   = mask_q & ~(4'b0001 << cur_lane);
    nxt_lane    = hi_lane(rest_mask);
    rbuf_next   = rbuf_q;
    if (!we_q) rbuf_next[{cur_lane, 3'b000} +: 8] = reg_rdata_i;

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          wadr_d = wb_adr_i[ADDR_W-1:2];
          we_d   = wb_we_i;
          wdat_d = wb_dat_i;
          rbuf_d = '0;
          mask_d = wb_sel_i;
          if (wb_sel_i != 4'b0000) begin
            reg_addr_d  = {wb_adr_i[ADDR_W-1:2], first_lane};
            reg_we_d    = wb_we_i;
            reg_wdata_d = wb_dat_i[{first_lane, 3'b000} +: 8];
            state_d     = XFER;
          end else begin
            ack_d    = 1'b1;
            wb_dat_d = '0;
            state_d  = ACK;
          end
        end
      end
      XFER: begin
        // Lanes run to completion even if the master drops cyc, so a word is never half-updated.
        rbuf_d = rbuf_next;
        mask_d = rest_mask;
        if (rest_mask != 4'b0000) begin
          reg_addr_d  = {wadr_q, nxt_lane};
          reg_we_d    = we_q;
          reg_wdata_d = wdat_q[{nxt_lane, 3'b000} +: 8];
        end else begin
          reg_we_d = 1'b0;
          ack_d    = wb_cyc_i;
          wb_dat_d = we_q ? 32'h0 : rbuf_next;
          state_d  = ACK;
        end
      end
      ACK: begin
        wb_dat_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      wadr_q      <= '0;
      we_q        <= 1'b0;
      wdat_q      <= '0;
      rbuf_q      <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      ack_q       <= 1'b0;
      wb_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      wadr_q      <= wadr_d;
      we_q        <= we_d;
      wdat_q      <= wdat_d;
      rbuf_q      <= rbuf_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      ack_q       <= ack_d;
      wb_dat_q    <= wb_dat_d;
    end
  end

  assign wb_dat_o    = wb_dat_q;
  assign wb_ack_o    = ack_q;
  assign reg_we_o    = reg_we_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;

endmodule
